// File: rtl/mem_max_scan.sv
// Register-file memory (1W/1R, registered read) with a sequential max-value scan engine.
// Optional MIN_SCAN_EN adds min_val/min_idx tracked in the same scan pass.
module mem_max_scan #(
  parameter  int DATA_W = 4,
  parameter  int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] max_val,
  output logic [ADDR_W-1:0] max_idx
`ifdef MIN_SCAN_EN
  ,
  output logic [DATA_W-1:0] min_val,
  output logic [ADDR_W-1:0] min_idx
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [1:0]        state;
  logic [ADDR_W-1:0] ptr;
  logic [DATA_W-1:0] acc;
  logic [ADDR_W-1:0] acc_idx;

  logic [DATA_W-1:0] cur;
  logic              take_max;
  logic              last;
  logic [DATA_W-1:0] acc_nxt;
  logic [ADDR_W-1:0] idx_nxt;

  // Contents survive reset on purpose: this is scratch storage, not state.
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  // Scan sees the word before any same-edge write lands.
  assign cur      = mem[ptr];
  assign take_max = (cur >= acc);
  assign last     = (ptr == ADDR_W'(DEPTH - 1));
  assign acc_nxt  = take_max ? cur : acc;
  assign idx_nxt  = take_max ? ptr : acc_idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      ptr     <= '0;
      acc     <= '0;
      acc_idx <= '0;
      max_val <= '0;
      max_idx <= '0;
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_addr];
      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_SCAN;
            ptr     <= '0;
            acc     <= '0;
            acc_idx <= '0;
          end
        end
        S_SCAN: begin
          acc     <= acc_nxt;
          acc_idx <= idx_nxt;
          if (last) begin
            state   <= S_DONE;
            max_val <= acc_nxt;
            max_idx <= idx_nxt;
          end else begin
            ptr <= ptr + ADDR_W'(1);
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state == S_SCAN);
  assign done = (state == S_DONE);

`ifdef MIN_SCAN_EN
  logic [DATA_W-1:0] mn_acc;
  logic [ADDR_W-1:0] mn_idx;
  logic              take_min;
  logic [DATA_W-1:0] mn_nxt;
  logic [ADDR_W-1:0] mn_idx_nxt;

  // Strict compare keeps the lowest index among equal minima.
  assign take_min   = (cur < mn_acc);
  assign mn_nxt     = take_min ? cur : mn_acc;
  assign mn_idx_nxt = take_min ? ptr : mn_idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      mn_acc  <= '1;
      mn_idx  <= '0;
      min_val <= '0;
      min_idx <= '0;
    end else begin
      if (state == S_IDLE && start) begin
        mn_acc <= '1;
        mn_idx <= '0;
      end else if (state == S_SCAN) begin
        mn_acc <= mn_nxt;
        mn_idx <= mn_idx_nxt;
        if (last) begin
          min_val <= mn_nxt;
          min_idx <= mn_idx_nxt;
        end
      end
    end
  end
`else
  // Max-only build: no min accumulator.
`endif

endmodule

// File: tb/tb_mem_max_scan.sv
// Self-checking bench for mem_max_scan: directed vector table, hand sequences, random scans.
module tb_mem_max_scan;
  localparam int DW = 4;
  localparam int DEPTH = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset, we, start, busy, done;
  logic [AW-1:0] wr_addr, rd_addr, max_idx;
  logic [DW-1:0] wr_data, rd_data, max_val;
`ifdef MIN_SCAN_EN
  logic [DW-1:0] min_val;
  logic [AW-1:0] min_idx;
`endif

  always #5 clk = ~clk;

  mem_max_scan #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .start(start), .busy(busy), .done(done),
    .max_val(max_val), .max_idx(max_idx)
`ifdef MIN_SCAN_EN
    , .min_val(min_val), .min_idx(min_idx)
`endif
  );

  typedef struct {
    int pat; int wcyc; int wa; int wd;
    int emax; int eidx; int emin; int emidx;
  } vec_t;

  int n_chk = 0;
  int n_pass = 0;
  int mem_m [DEPTH];
  int pat0 [DEPTH] = '{1,3,9,7,8,12,5,0,1,7,9,14,2,15,1,0};
  int last_max = 0, last_idx = 0, last_min = 0, last_midx = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  // One clock: model write and registered-read expectation, then sample after the edge.
  task automatic tick();
    int exp_rd;
    exp_rd = reset ? 0 : mem_m[rd_addr];
    if (we) mem_m[wr_addr] = int'(wr_data);
    @(posedge clk); #1;
    chk("rd_data", int'(rd_data), exp_rd);
  endtask

  task automatic load(input int pat, input int span);
    for (int a = 0; a < DEPTH; a++) begin
      we = 1'b1;
      wr_addr = AW'(a);
      case (pat)
        0:       wr_data = DW'(pat0[a]);
        1:       wr_data = '0;
        2:       wr_data = (a == 2 || a == 10) ? DW'(9) : DW'(0);
        default: wr_data = DW'($urandom_range(0, span));
      endcase
      rd_addr = AW'($urandom_range(0, DEPTH - 1));
      tick();
    end
    we = 1'b0;
  endtask

  // Reference: address a is scanned at edge a+1 relative to start, so a write at edge wcyc is seen iff wcyc <= a.
  task automatic expect_scan(input int wcyc, input int wa, input int wd,
                             output int emax, output int eidx, output int emin, output int emidx);
    int v;
    emax = -1; eidx = 0; emin = 1 << DW; emidx = 0;
    for (int a = 0; a < DEPTH; a++) begin
      v = (wcyc > 0 && wa == a && wcyc <= a) ? wd : mem_m[a];
      if (v >= emax) begin emax = v; eidx = a; end
      if (v < emin) begin emin = v; emidx = a; end
    end
  endtask

  task automatic run_scan(input string nm, input int wcyc, input int wa, input int wd,
                          input int emax, input int eidx, input int emin, input int emidx,
                          input bit noise);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({nm, ".busy0"}, int'(busy), 1);
    chk({nm, ".done0"}, int'(done), 0);
    for (int k = 1; k <= DEPTH; k++) begin
      rd_addr = AW'($urandom_range(0, DEPTH - 1));
      if (noise) start = 1'($urandom_range(0, 1));
      if (k == wcyc) begin
        we = 1'b1; wr_addr = AW'(wa); wr_data = DW'(wd);
      end
      tick();
      we = 1'b0;
      chk({nm, ".busy"}, int'(busy), int'(k < DEPTH));
      chk({nm, ".done"}, int'(done), int'(k == DEPTH));
      chk({nm, ".max_val"}, int'(max_val), (k < DEPTH) ? last_max : emax);
      chk({nm, ".max_idx"}, int'(max_idx), (k < DEPTH) ? last_idx : eidx);
`ifdef MIN_SCAN_EN
      chk({nm, ".min_val"}, int'(min_val), (k < DEPTH) ? last_min : emin);
      chk({nm, ".min_idx"}, int'(min_idx), (k < DEPTH) ? last_midx : emidx);
`endif
    end
    // start during DONE must be ignored
    if (noise) start = 1'($urandom_range(0, 1));
    tick();
    start = 1'b0;
    chk({nm, ".busy_end"}, int'(busy), 0);
    chk({nm, ".done_end"}, int'(done), 0);
    chk({nm, ".max_hold"}, int'(max_val), emax);
    last_max = emax; last_idx = eidx; last_min = emin; last_midx = emidx;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t vt [7];
    int emax, eidx, emin, emidx, old, wcyc, wa, wd;

    vt[0] = '{0, 0, 0, 0, 15, 13, 0, 7};
    vt[1] = '{1, 0, 0, 0, 0, 15, 0, 0};
    vt[2] = '{2, 0, 0, 0, 9, 10, 0, 0};
    vt[3] = '{0, 2, 14, 15, 15, 14, 0, 7};
    vt[4] = '{0, 5, 0, 15, 15, 13, 0, 7};
    vt[5] = '{0, 14, 13, 0, 15, 13, 0, 7};
    vt[6] = '{0, 13, 13, 0, 14, 11, 0, 7};

    reset = 1'b1; we = 1'b0; start = 1'b0;
    wr_addr = '0; wr_data = '0; rd_addr = '0;
    tick(); tick();
    chk("reset.busy", int'(busy), 0);
    chk("reset.done", int'(done), 0);
    chk("reset.max_val", int'(max_val), 0);
    chk("reset.max_idx", int'(max_idx), 0);
`ifdef MIN_SCAN_EN
    chk("reset.min_val", int'(min_val), 0);
    chk("reset.min_idx", int'(min_idx), 0);
`endif
    reset = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) begin
      load(vt[i].pat, 15);
      run_scan($sformatf("vec%0d", i), vt[i].wcyc, vt[i].wa, vt[i].wd,
               vt[i].emax, vt[i].eidx, vt[i].emin, vt[i].emidx, 1'b0);
    end

    // Read-before-write collision, then the new value one cycle later.
    load(0, 15);
    old = mem_m[3];
    rd_addr = 3; we = 1'b1; wr_addr = 3; wr_data = 4'hA;
    tick();
    we = 1'b0;
    chk("rd_collide_old", int'(rd_data), old);
    tick();
    chk("rd_after_write", int'(rd_data), 10);

    // Reset in the middle of a scan.
    load(0, 15);
    run_scan("prime", 0, 0, 0, 15, 13, 0, 7, 1'b0);
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 1; k < 8; k++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_mid.busy", int'(busy), 0);
    chk("rst_mid.done", int'(done), 0);
    chk("rst_mid.max_val", int'(max_val), 0);
    chk("rst_mid.max_idx", int'(max_idx), 0);
`ifdef MIN_SCAN_EN
    chk("rst_mid.min_val", int'(min_val), 0);
    chk("rst_mid.min_idx", int'(min_idx), 0);
`endif
    last_max = 0; last_idx = 0; last_min = 0; last_midx = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("rst_mid.no_done", int'(done), 0);
      chk("rst_mid.idle", int'(busy), 0);
    end
    expect_scan(0, 0, 0, emax, eidx, emin, emidx);
    run_scan("after_rst", 0, 0, 0, emax, eidx, emin, emidx, 1'b0);

    // start held high: next scan accepted only after the idle cycle following done.
    start = 1'b1;
    tick();
    for (int k = 1; k <= DEPTH; k++) begin
      tick();
      chk("held.busy", int'(busy), int'(k < DEPTH));
      chk("held.done", int'(done), int'(k == DEPTH));
    end
    tick();
    chk("held.gap_busy", int'(busy), 0);
    chk("held.gap_done", int'(done), 0);
    tick();
    chk("held.restart", int'(busy), 1);
    start = 1'b0;
    for (int k = 1; k <= DEPTH; k++) begin
      tick();
      chk("held2.done", int'(done), int'(k == DEPTH));
    end
    chk("held2.max_val", int'(max_val), emax);
    chk("held2.max_idx", int'(max_idx), eidx);
    tick();

    // Randomized scans with one random write during the scan and start noise.
    for (int it = 0; it < 24; it++) begin
      load(3, (it % 2) ? 3 : 15);
      wcyc = $urandom_range(0, DEPTH);
      wa = $urandom_range(0, DEPTH - 1);
      wd = $urandom_range(0, 15);
      expect_scan(wcyc, wa, wd, emax, eidx, emin, emidx);
      run_scan($sformatf("rnd%0d", it), wcyc, wa, wd, emax, eidx, emin, emidx, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
